// File: rtl/fp_pkg.sv
// Shared floating-point constants, field widths and the int->float FSM state type.
// No ports; imported by the converter and the rounding helper.
package fp_pkg;

  localparam int FP_BIAS = 127;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;

  localparam logic [EXP_W-1:0] I2F_EXP_INIT = 8'd158;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    HOLD
  } i2f_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational mantissa rounder: round-to-nearest-even or truncate.
// Ports: frac/guard/sticky/mode in; frac_rnd, carry, inexact out.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  input  logic              mode,
  output logic [FRAC_W-1:0] frac_rnd,
  output logic              carry,
  output logic              inexact
);

  logic inc;

  // Ties go to the even mantissa: bump only when the lsb is odd.
  assign inc = mode & guard & (sticky | frac[0]);

  // On carry-out the sum wraps frac_rnd to zero.
  assign {carry, frac_rnd} = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};

  assign inexact = guard | sticky;

endmodule

// File: rtl/int2float_seq.sv
// Multi-cycle signed int32 -> IEEE-754 single converter (valid/ready both sides).
// Ports: clk, rst_n, in_valid/in_ready/int_in, out_valid/out_ready/float_out/precision_lost.
module int2float_seq
  import fp_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1,
  parameter int NORM_SHIFT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] float_out,
  output logic        precision_lost
);

  localparam logic [EXP_W-1:0] NS = EXP_W'(NORM_SHIFT);

  i2f_state_t state, state_nx;

  logic             sign_q;
  logic             zero_q;
  logic [31:0]      mag_q;
  logic [EXP_W-1:0] exp_q;

  logic [FRAC_W-1:0] frac_rnd;
  logic              carry;
  logic              inexact;
  logic              accept;
  logic [EXP_W-1:0]  exp_rnd;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  fp_round_rne u_round (
    .frac     (mag_q[30:8]),
    .guard    (mag_q[7]),
    .sticky   (|mag_q[6:0]),
    .mode     (ROUND_NEAREST),
    .frac_rnd (frac_rnd),
    .carry    (carry),
    .inexact  (inexact)
  );

  assign exp_rnd = exp_q + {{(EXP_W-1){1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = (int_in == 32'd0) ? ROUND : NORM;
      end
      NORM: begin
        if (mag_q[31]) state_nx = ROUND;
      end
      ROUND: state_nx = HOLD;
      HOLD: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      mag_q  <= '0;
      exp_q  <= '0;
    end else if (accept) begin
      sign_q <= int_in[31];
      zero_q <= (int_in == 32'd0);
      mag_q  <= int_in[31] ? (~int_in + 32'd1) : int_in;
      exp_q  <= I2F_EXP_INIT;
    end else if (state == NORM && !mag_q[31]) begin
      // Take the wide step only when it cannot overshoot the leading one.
      if (mag_q[31 -: NORM_SHIFT] == '0) begin
        mag_q <= mag_q << NORM_SHIFT;
        exp_q <= exp_q - NS;
      end else begin
        mag_q <= mag_q << 1;
        exp_q <= exp_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      float_out      <= '0;
      precision_lost <= 1'b0;
    end else if (state == ROUND) begin
      out_valid <= 1'b1;
      if (zero_q) begin
        float_out      <= 32'h0000_0000;
        precision_lost <= 1'b0;
      end else begin
        float_out      <= {sign_q, exp_rnd, frac_rnd};
        precision_lost <= inexact;
      end
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int2float_seq.sv
// Directed self-checking bench: RNE and truncate instances side by side.
// Checks results, latency, backpressure and mid-operation reset.
module tb_int2float_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] int_in;
  logic        out_ready;

  logic        in_ready_n, in_ready_t;
  logic        out_valid_n, out_valid_t;
  logic [31:0] float_n, float_t;
  logic        lost_n, lost_t;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  int2float_seq #(.ROUND_NEAREST(1'b1), .NORM_SHIFT(1)) u_rne (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready_n),
    .int_in         (int_in),
    .out_valid      (out_valid_n),
    .out_ready      (out_ready),
    .float_out      (float_n),
    .precision_lost (lost_n)
  );

  int2float_seq #(.ROUND_NEAREST(1'b0), .NORM_SHIFT(1)) u_trn (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready_t),
    .int_in         (int_in),
    .out_valid      (out_valid_t),
    .out_ready      (out_ready),
    .float_out      (float_t),
    .precision_lost (lost_t)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns edges from accept to out_valid, or -1 on timeout.
  task automatic launch(input logic [31:0] v, output int lat);
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready_n}, 32'd1);
    in_valid = 1'b1;
    int_in   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_n && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid_n) lat = -1;
  endtask

  task automatic handoff();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", {30'd0, out_valid_n, out_valid_t}, 32'd0);
    check("ready_back", {30'd0, in_ready_n, in_ready_t}, 32'd3);
  endtask

  task automatic convert(input string tag,
                         input logic [31:0] v,
                         input logic [31:0] exp_n,
                         input logic [31:0] exp_t,
                         input logic        exp_lost,
                         input int          exp_lat);
    int lat;
    launch(v, lat);
    if (lat < 0) begin
      check({tag, "_timeout"}, 32'd1, 32'd0);
    end else begin
      if (exp_lat >= 0)
        check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_rne"}, float_n, exp_n);
      check({tag, "_trn"}, float_t, exp_t);
      check({tag, "_lost"}, {30'd0, lost_n, lost_t},
            {30'd0, exp_lost, exp_lost});
      check({tag, "_vt"}, {31'd0, out_valid_t}, 32'd1);
    end
    handoff();
  endtask

  initial begin
    int bad;
    int lat;
    logic [31:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    int_in    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {30'd0, out_valid_n, out_valid_t}, 32'd0);
    check("rst_float", float_n | float_t, 32'd0);
    check("rst_lost", {30'd0, lost_n, lost_t}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", {30'd0, in_ready_n, in_ready_t}, 32'd3);

    convert("one",   32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 33);
    convert("neg1",  32'hFFFF_FFFF, 32'hBF80_0000, 32'hBF80_0000, 1'b0, 33);
    convert("zero",  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1);
    convert("minint",32'h8000_0000, 32'hCF00_0000, 32'hCF00_0000, 1'b0, 2);
    convert("tie",   32'h0100_0001, 32'h4B80_0000, 32'h4B80_0000, 1'b1, 9);
    convert("rndup", 32'h0100_0003, 32'h4B80_0002, 32'h4B80_0001, 1'b1, -1);
    convert("maxint",32'h7FFF_FFFF, 32'h4F00_0000, 32'h4EFF_FFFF, 1'b1, 3);
    convert("three", 32'h0000_0003, 32'h4040_0000, 32'h4040_0000, 1'b0, 32);
    convert("neg5",  32'hFFFF_FFFB, 32'hC0A0_0000, 32'hC0A0_0000, 1'b0, -1);

    // Backpressure: result must stay put and new inputs must be ignored.
    launch(32'h0000_0003, lat);
    check("bp_lat", lat, 32);
    held = float_n;
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      int_in   = 32'h0000_0100 + i;
      if (!out_valid_n || in_ready_n || float_n !== held) bad++;
    end
    in_valid = 1'b0;
    check("bp_stable", bad, 0);
    check("bp_value", float_n, 32'h4040_0000);
    handoff();

    // Reset during NORM drops the conversion.
    @(negedge clk);
    in_valid = 1'b1;
    int_in   = 32'h0000_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready", {31'd0, in_ready_n}, 32'd1);
    check("mid_rst_valid", {31'd0, out_valid_n}, 32'd0);
    check("mid_rst_float", float_n, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid_n || out_valid_t) bad++;
    end
    check("no_stale", bad, 0);

    convert("post",  32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
